// File: rtl/id_ex_stage_reg_if.sv
// ============================================================================
// id_ex_stage_reg_if : decode/execute/writeback bundle for the ID/EX register
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

interface id_ex_stage_reg_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int CNT_WIDTH      = 16
);
  logic                      id_valid;
  logic [DATA_WIDTH-1:0]     id_pc;
  logic [DATA_WIDTH-1:0]     id_pc_plus4;
  logic [REG_ADDR_WIDTH-1:0] id_rs1;
  logic [REG_ADDR_WIDTH-1:0] id_rs2;
  logic [REG_ADDR_WIDTH-1:0] id_rd;
  logic [DATA_WIDTH-1:0]     id_rd1;
  logic [DATA_WIDTH-1:0]     id_rd2;
  logic [DATA_WIDTH-1:0]     id_imm;
  logic                      id_reg_write;
  logic                      id_mem_read;
  logic                      id_mem_write;
  logic                      id_alu_src;
  logic                      id_jump;
  logic                      id_branch;
  logic [1:0]                id_result_src;
  logic [3:0]                id_alu_ctrl;

  logic                      ex_flush;
  logic                      wb_we;
  logic [REG_ADDR_WIDTH-1:0] wb_rd;
  logic [DATA_WIDTH-1:0]     wb_wd;

  logic                      stall_fd;
  logic                      ex_valid;
  logic [DATA_WIDTH-1:0]     ex_pc;
  logic [DATA_WIDTH-1:0]     ex_pc_plus4;
  logic [REG_ADDR_WIDTH-1:0] ex_rs1;
  logic [REG_ADDR_WIDTH-1:0] ex_rs2;
  logic [REG_ADDR_WIDTH-1:0] ex_rd;
  logic [DATA_WIDTH-1:0]     ex_rd1;
  logic [DATA_WIDTH-1:0]     ex_rd2;
  logic [DATA_WIDTH-1:0]     ex_imm;
  logic                      ex_reg_write;
  logic                      ex_mem_read;
  logic                      ex_mem_write;
  logic                      ex_alu_src;
  logic                      ex_jump;
  logic                      ex_branch;
  logic [1:0]                ex_result_src;
  logic [3:0]                ex_alu_ctrl;
  logic [CNT_WIDTH-1:0]      bubble_count;

  modport slave (
    input  id_valid, id_pc, id_pc_plus4, id_rs1, id_rs2, id_rd, id_rd1, id_rd2,
           id_imm, id_reg_write, id_mem_read, id_mem_write, id_alu_src, id_jump,
           id_branch, id_result_src, id_alu_ctrl, ex_flush, wb_we, wb_rd, wb_wd,
    output stall_fd, ex_valid, ex_pc, ex_pc_plus4, ex_rs1, ex_rs2, ex_rd, ex_rd1,
           ex_rd2, ex_imm, ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_src,
           ex_jump, ex_branch, ex_result_src, ex_alu_ctrl, bubble_count
  );

  modport master (
    output id_valid, id_pc, id_pc_plus4, id_rs1, id_rs2, id_rd, id_rd1, id_rd2,
           id_imm, id_reg_write, id_mem_read, id_mem_write, id_alu_src, id_jump,
           id_branch, id_result_src, id_alu_ctrl, ex_flush, wb_we, wb_rd, wb_wd,
    input  stall_fd, ex_valid, ex_pc, ex_pc_plus4, ex_rs1, ex_rs2, ex_rd, ex_rd1,
           ex_rd2, ex_imm, ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_src,
           ex_jump, ex_branch, ex_result_src, ex_alu_ctrl, bubble_count
  );
endinterface

`default_nettype wire

// File: rtl/id_ex_stage_reg.sv
// ============================================================================
// id_ex_stage_reg : ID/EX pipeline register with load-use stall, flush bubbles
// and saturating bubble counter. Optional writeback bypass: ID_EX_WB_BYPASS_EN
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module id_ex_stage_reg #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int CNT_WIDTH      = 16
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  id_ex_stage_reg_if.slave   bus
);

  localparam logic [CNT_WIDTH-1:0] c_CNT_MAX = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] c_CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic                      r_ex_valid;
  logic [DATA_WIDTH-1:0]     r_ex_pc;
  logic [DATA_WIDTH-1:0]     r_ex_pc_plus4;
  logic [REG_ADDR_WIDTH-1:0] r_ex_rs1;
  logic [REG_ADDR_WIDTH-1:0] r_ex_rs2;
  logic [REG_ADDR_WIDTH-1:0] r_ex_rd;
  logic [DATA_WIDTH-1:0]     r_ex_rd1;
  logic [DATA_WIDTH-1:0]     r_ex_rd2;
  logic [DATA_WIDTH-1:0]     r_ex_imm;
  logic                      r_ex_reg_write;
  logic                      r_ex_mem_read;
  logic                      r_ex_mem_write;
  logic                      r_ex_alu_src;
  logic                      r_ex_jump;
  logic                      r_ex_branch;
  logic [1:0]                r_ex_result_src;
  logic [3:0]                r_ex_alu_ctrl;
  logic [CNT_WIDTH-1:0]      r_bubble_count;

  logic                      w_load_use;
  logic                      w_bubble;
  logic [DATA_WIDTH-1:0]     w_rd1;
  logic [DATA_WIDTH-1:0]     w_rd2;

  // x0 is never a real destination, so a load into it cannot create a hazard
  assign w_load_use = bus.id_valid & r_ex_valid & r_ex_mem_read &
                      (r_ex_rd != '0) &
                      ((r_ex_rd == bus.id_rs1) | (r_ex_rd == bus.id_rs2));
  assign w_bubble   = bus.ex_flush | w_load_use;
  assign bus.stall_fd = w_load_use & ~bus.ex_flush;

`ifdef ID_EX_WB_BYPASS_EN
  assign w_rd1 = (bus.wb_we && (bus.wb_rd != '0) && (bus.wb_rd == bus.id_rs1)) ?
                 bus.wb_wd : bus.id_rd1;
  assign w_rd2 = (bus.wb_we && (bus.wb_rd != '0) && (bus.wb_rd == bus.id_rs2)) ?
                 bus.wb_wd : bus.id_rd2;
`else
  wire w_unused_wb = ^{bus.wb_we, bus.wb_rd, bus.wb_wd};
  assign w_rd1 = bus.id_rd1;
  assign w_rd2 = bus.id_rd2;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n || w_bubble) begin
      r_ex_valid      <= 1'b0;
      r_ex_pc         <= '0;
      r_ex_pc_plus4   <= '0;
      r_ex_rs1        <= '0;
      r_ex_rs2        <= '0;
      r_ex_rd         <= '0;
      r_ex_rd1        <= '0;
      r_ex_rd2        <= '0;
      r_ex_imm        <= '0;
      r_ex_reg_write  <= 1'b0;
      r_ex_mem_read   <= 1'b0;
      r_ex_mem_write  <= 1'b0;
      r_ex_alu_src    <= 1'b0;
      r_ex_jump       <= 1'b0;
      r_ex_branch     <= 1'b0;
      r_ex_result_src <= 2'b00;
      r_ex_alu_ctrl   <= 4'b0000;
    end else begin
      r_ex_valid      <= bus.id_valid;
      r_ex_pc         <= bus.id_pc;
      r_ex_pc_plus4   <= bus.id_pc_plus4;
      r_ex_rs1        <= bus.id_rs1;
      r_ex_rs2        <= bus.id_rs2;
      r_ex_rd         <= bus.id_rd;
      r_ex_rd1        <= w_rd1;
      r_ex_rd2        <= w_rd2;
      r_ex_imm        <= bus.id_imm;
      // An empty decode slot must not leak side-effecting controls into EX
      r_ex_reg_write  <= bus.id_reg_write & bus.id_valid;
      r_ex_mem_read   <= bus.id_mem_read  & bus.id_valid;
      r_ex_mem_write  <= bus.id_mem_write & bus.id_valid;
      r_ex_alu_src    <= bus.id_alu_src   & bus.id_valid;
      r_ex_jump       <= bus.id_jump      & bus.id_valid;
      r_ex_branch     <= bus.id_branch    & bus.id_valid;
      r_ex_result_src <= bus.id_result_src & {2{bus.id_valid}};
      r_ex_alu_ctrl   <= bus.id_alu_ctrl   & {4{bus.id_valid}};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_bubble_count <= '0;
    end else if (w_bubble && (r_bubble_count != c_CNT_MAX)) begin
      r_bubble_count <= r_bubble_count + c_CNT_ONE;
    end
  end

  assign bus.ex_valid      = r_ex_valid;
  assign bus.ex_pc         = r_ex_pc;
  assign bus.ex_pc_plus4   = r_ex_pc_plus4;
  assign bus.ex_rs1        = r_ex_rs1;
  assign bus.ex_rs2        = r_ex_rs2;
  assign bus.ex_rd         = r_ex_rd;
  assign bus.ex_rd1        = r_ex_rd1;
  assign bus.ex_rd2        = r_ex_rd2;
  assign bus.ex_imm        = r_ex_imm;
  assign bus.ex_reg_write  = r_ex_reg_write;
  assign bus.ex_mem_read   = r_ex_mem_read;
  assign bus.ex_mem_write  = r_ex_mem_write;
  assign bus.ex_alu_src    = r_ex_alu_src;
  assign bus.ex_jump       = r_ex_jump;
  assign bus.ex_branch     = r_ex_branch;
  assign bus.ex_result_src = r_ex_result_src;
  assign bus.ex_alu_ctrl   = r_ex_alu_ctrl;
  assign bus.bubble_count  = r_bubble_count;

endmodule

`default_nettype wire

// File: tb/tb_id_ex_stage_reg.sv
// ============================================================================
// tb_id_ex_stage_reg : directed checks for the ID/EX register (CNT_WIDTH = 4)
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_id_ex_stage_reg;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  id_ex_stage_reg_if #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5), .CNT_WIDTH(4)) bus ();

  id_ex_stage_reg #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5), .CNT_WIDTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clr_id();
    bus.id_valid      = 1'b0;
    bus.id_pc         = '0;
    bus.id_pc_plus4   = '0;
    bus.id_rs1        = '0;
    bus.id_rs2        = '0;
    bus.id_rd         = '0;
    bus.id_rd1        = '0;
    bus.id_rd2        = '0;
    bus.id_imm        = '0;
    bus.id_reg_write  = 1'b0;
    bus.id_mem_read   = 1'b0;
    bus.id_mem_write  = 1'b0;
    bus.id_alu_src    = 1'b0;
    bus.id_jump       = 1'b0;
    bus.id_branch     = 1'b0;
    bus.id_result_src = 2'b00;
    bus.id_alu_ctrl   = 4'h0;
  endtask

  task automatic set_instr(input logic [31:0] pc, input logic [4:0] rs1, rs2, rd,
                           input logic [31:0] rd1, input logic memr);
    clr_id();
    bus.id_valid     = 1'b1;
    bus.id_pc        = pc;
    bus.id_pc_plus4  = pc + 32'd4;
    bus.id_rs1       = rs1;
    bus.id_rs2       = rs2;
    bus.id_rd        = rd;
    bus.id_rd1       = rd1;
    bus.id_reg_write = 1'b1;
    bus.id_mem_read  = memr;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    clr_id();
    bus.ex_flush = 1'b0;
    bus.wb_we    = 1'b0;
    bus.wb_rd    = '0;
    bus.wb_wd    = '0;

    // reset with a live instruction presented
    rst_n = 1'b0;
    bus.id_valid     = 1'b1;
    bus.id_reg_write = 1'b1;
    step();
    step();
    chk("rst_ex_valid", {31'b0, bus.ex_valid}, 32'd0);
    chk("rst_reg_write", {31'b0, bus.ex_reg_write}, 32'd0);
    chk("rst_bubble_cnt", {28'b0, bus.bubble_count}, 32'd0);
    chk("rst_stall_fd", {31'b0, bus.stall_fd}, 32'd0);

    // pass-through
    rst_n = 1'b1;
    set_instr(32'h100, 5'd1, 5'd2, 5'd5, 32'hDEADBEEF, 1'b0);
    bus.id_imm = 32'hFFFF_FFF0;
    step();
    chk("pt_pc", bus.ex_pc, 32'h100);
    chk("pt_pc4", bus.ex_pc_plus4, 32'h104);
    chk("pt_rd1", bus.ex_rd1, 32'hDEADBEEF);
    chk("pt_imm", bus.ex_imm, 32'hFFFF_FFF0);
    chk("pt_rd", {27'b0, bus.ex_rd}, 32'd5);
    chk("pt_valid", {31'b0, bus.ex_valid}, 32'd1);
    chk("pt_reg_write", {31'b0, bus.ex_reg_write}, 32'd1);
    chk("pt_bubble_cnt", {28'b0, bus.bubble_count}, 32'd0);

    // load-use: lw x6 then consumer with rs2 = 6
    set_instr(32'h104, 5'd1, 5'd0, 5'd6, 32'h0, 1'b1);
    step();
    set_instr(32'h108, 5'd9, 5'd6, 5'd7, 32'h22, 1'b0);
    #1;
    chk("lu_stall", {31'b0, bus.stall_fd}, 32'd1);
    step();
    chk("lu_bub_valid", {31'b0, bus.ex_valid}, 32'd0);
    chk("lu_bub_regw", {31'b0, bus.ex_reg_write}, 32'd0);
    chk("lu_bub_memr", {31'b0, bus.ex_mem_read}, 32'd0);
    chk("lu_bub_pc", bus.ex_pc, 32'h0);
    chk("lu_bub_cnt", {28'b0, bus.bubble_count}, 32'd1);
    chk("lu_stall_end", {31'b0, bus.stall_fd}, 32'd0);
    step();
    chk("lu_cap_pc", bus.ex_pc, 32'h108);
    chk("lu_cap_rd", {27'b0, bus.ex_rd}, 32'd7);
    chk("lu_cap_valid", {31'b0, bus.ex_valid}, 32'd1);
    chk("lu_cap_cnt", {28'b0, bus.bubble_count}, 32'd1);

    // lw x0 never stalls
    set_instr(32'h10C, 5'd1, 5'd0, 5'd0, 32'h0, 1'b1);
    step();
    chk("x0_ex_memr", {31'b0, bus.ex_mem_read}, 32'd1);
    set_instr(32'h110, 5'd0, 5'd5, 5'd8, 32'h0, 1'b0);
    #1;
    chk("x0_stall", {31'b0, bus.stall_fd}, 32'd0);

    // lw x6 with unrelated sources
    set_instr(32'h110, 5'd1, 5'd0, 5'd6, 32'h0, 1'b1);
    step();
    set_instr(32'h114, 5'd7, 5'd8, 5'd9, 32'h0, 1'b0);
    #1;
    chk("nodep_stall", {31'b0, bus.stall_fd}, 32'd0);
    step();
    chk("nodep_valid", {31'b0, bus.ex_valid}, 32'd1);

    // flush and load-use together
    set_instr(32'h118, 5'd1, 5'd0, 5'd6, 32'h0, 1'b1);
    step();
    set_instr(32'h11C, 5'd6, 5'd0, 5'd10, 32'h0, 1'b0);
    bus.ex_flush = 1'b1;
    #1;
    chk("fl_lu_stall", {31'b0, bus.stall_fd}, 32'd0);
    step();
    bus.ex_flush = 1'b0;
    chk("fl_lu_valid", {31'b0, bus.ex_valid}, 32'd0);
    chk("fl_lu_memr", {31'b0, bus.ex_mem_read}, 32'd0);
    chk("fl_lu_cnt", {28'b0, bus.bubble_count}, 32'd2);
    step();
    chk("fl_after_valid", {31'b0, bus.ex_valid}, 32'd1);
    chk("fl_after_pc", bus.ex_pc, 32'h11C);

    // writeback bypass (or not, in the default build)
    set_instr(32'h120, 5'd3, 5'd4, 5'd11, 32'h11, 1'b0);
    bus.id_rd2 = 32'h22;
    bus.wb_we  = 1'b1;
    bus.wb_rd  = 5'd3;
    bus.wb_wd  = 32'h55;
    step();
`ifdef ID_EX_WB_BYPASS_EN
    chk("wb_rd1", bus.ex_rd1, 32'h55);
`else
    chk("wb_rd1", bus.ex_rd1, 32'h11);
`endif
    chk("wb_rd2", bus.ex_rd2, 32'h22);
    bus.wb_we = 1'b0;

    // invalid decode slot: controls gated, data still captured
    set_instr(32'h124, 5'd1, 5'd2, 5'd12, 32'h0, 1'b1);
    bus.id_valid     = 1'b0;
    bus.id_mem_write = 1'b1;
    step();
    chk("inv_valid", {31'b0, bus.ex_valid}, 32'd0);
    chk("inv_regw", {31'b0, bus.ex_reg_write}, 32'd0);
    chk("inv_memw", {31'b0, bus.ex_mem_write}, 32'd0);
    chk("inv_pc", bus.ex_pc, 32'h124);

    // counter saturation: from 2, 12 flushes -> 14, 20 total -> 15
    clr_id();
    bus.ex_flush = 1'b1;
    for (int i = 0; i < 12; i++) step();
    chk("sat_cnt_14", {28'b0, bus.bubble_count}, 32'd14);
    for (int i = 0; i < 8; i++) step();
    chk("sat_cnt_15", {28'b0, bus.bubble_count}, 32'hF);
    bus.ex_flush = 1'b0;

    // mid-stream reset discards the instruction and clears the counter
    set_instr(32'h200, 5'd1, 5'd2, 5'd13, 32'h0, 1'b0);
    rst_n = 1'b0;
    step();
    chk("mrst_valid", {31'b0, bus.ex_valid}, 32'd0);
    chk("mrst_cnt", {28'b0, bus.bubble_count}, 32'd0);
    rst_n = 1'b1;
    step();
    chk("mrst_cap_pc", bus.ex_pc, 32'h200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/id_ex_stage_reg.md
# id_ex_stage_reg

Pipeline register between decode and execute in the pipelined RV32I core. Captures the two register-file read operands, immediate, PC and decoded control bundle each cycle. Detects load-use hazards and emits a decode/fetch stall. Inserts bubbles on stall or on a taken-branch flush from execute, and keeps a saturating bubble counter for performance debug.

## Interface
- DATA_WIDTH, 32, operand/PC/immediate width
- REG_ADDR_WIDTH, 5, register specifier width
- CNT_WIDTH, 16, bubble counter width
- clk  in  1  core clock; all state updates on rising edge
- rst_n  in  1  reset, synchronous, active-low
- id_valid  in  1  decode slot holds a real instruction
- id_pc, id_pc_plus4  in  DATA_WIDTH  decode PC and PC+4
- id_rs1, id_rs2, id_rd  in  REG_ADDR_WIDTH  source/destination specifiers
- id_rd1, id_rd2  in  DATA_WIDTH  register-file read data (RD1/RD2)
- id_imm  in  DATA_WIDTH  sign-extended immediate
- id_reg_write, id_mem_read, id_mem_write, id_alu_src, id_jump, id_branch  in  1 each  decoded controls
- id_result_src  in  2  writeback mux select
- id_alu_ctrl  in  4  ALU operation
- ex_flush  in  1  taken branch/jump resolved in execute
- wb_we  in  1  writeback write enable (WE3)
- wb_rd  in  REG_ADDR_WIDTH  writeback address (AD3)
- wb_wd  in  DATA_WIDTH  writeback data (WD3)
- stall_fd  out  1  hold fetch PC and IF/ID register (combinational)
- ex_valid, ex_* (same names and widths as each id_* input except id_valid)  out  registered execute-stage copies
- bubble_count  out  CNT_WIDTH  saturating count of inserted bubbles

## Operation
- Hazard: load_use = id_valid & ex_valid & ex_mem_read & (ex_rd != 0) & ((ex_rd == id_rs1) | (ex_rd == id_rs2)).
- stall_fd = load_use & ~ex_flush.
- Register update, priority order:
  - ~rst_n: all ex_* outputs and ex_valid = 0; bubble_count = 0.
  - ex_flush: bubble (ex_valid and every control output = 0; data fields = 0).
  - load_use: bubble. Decode contents are held upstream by stall_fd and re-presented next cycle.
  - otherwise: capture all id_* fields; ex_valid <= id_valid. Controls are gated to 0 when id_valid = 0.
- bubble_count increments by 1 on each cycle a bubble is inserted by flush or load_use. It saturates at all-ones and never wraps.
- Bubbles are architecturally a NOP: reg_write = mem_write = mem_read = jump = branch = 0.
- x0 never creates a hazard. ex_rd = 0 with mem_read = 1 does not stall.

## Timing
- Latency: 1 cycle. id_* sampled at rising edge N appear on ex_* after edge N.
- stall_fd is combinational from current ex_* state and id_* inputs and is valid within the same cycle.
- A load followed directly by a dependent instruction costs exactly one stall cycle. The cycle after the bubble, load_use is 0 because ex_valid = 0.
- ex_flush and load_use in the same cycle: flush wins, stall_fd = 0, one bubble, bubble_count +1 (not +2).
- Reset mid-stream discards the captured instruction. The first capture is on the edge after rst_n returns to 1.
- Register file writes on the falling clock edge, so id_rd1/id_rd2 already reflect a same-cycle writeback at the rising edge.

## Configuration
- ID_EX_WB_BYPASS_EN defined:
  - If wb_we & (wb_rd != 0) & (wb_rd == id_rs1), ex_rd1 captures wb_wd instead of id_rd1. ex_rd2 is handled likewise using id_rs2.
  - Applies only on normal capture cycles.
  - Required if the register file moves to rising-edge write.
- ID_EX_WB_BYPASS_EN undefined: id_rd1/id_rd2 are captured unmodified, and the wb_* ports are ignored.

## Test plan
- Reset: drive rst_n = 0 for 2 cycles with id_valid = 1 and id_reg_write = 1 -> ex_valid = 0, ex_reg_write = 0, bubble_count = 0, stall_fd = 0.
- Pass-through: id_pc = 0x100, id_rd1 = 0xDEADBEEF, id_rd = 5, id_reg_write = 1 -> next cycle ex_pc = 0x100, ex_rd1 = 0xDEADBEEF, ex_rd = 5, ex_valid = 1.
- Load-use: `lw x6` in EX, then an instruction in decode with id_rs2 = 6 -> stall_fd = 1 for exactly one cycle, one bubble, bubble_count = 1; the dependent instruction is captured on the following edge.
- x0 and no-dependency cases:
  - `lw x0` in EX with id_rs1 = 0 -> stall_fd = 0.
  - `lw x6` in EX with id_rs1 = 7, id_rs2 = 8 -> stall_fd = 0.
- Flush with load_use in the same cycle -> stall_fd = 0, ex_valid = 0, bubble_count increments by exactly 1.
- Counter saturation with CNT_WIDTH = 4: 20 consecutive flushes -> bubble_count = 0xF. With ID_EX_WB_BYPASS_EN defined, wb_we = 1, wb_rd = 3, wb_wd = 0x55, id_rs1 = 3, id_rd1 = 0x11 -> ex_rd1 = 0x55; undefined -> ex_rd1 = 0x11.
